// File: rtl/core_sleep_ctrl_if.sv
// core_sleep_ctrl_if: sleep request / wake event inputs and clock-gate / status outputs of the sleep controller.
interface core_sleep_ctrl_if;
    logic        sleep_req_i;
    logic        core_busy_i;
    logic        irq_pending_i;
    logic        debug_req_i;
    logic        clr_stats_i;
    logic        clock_en_o;
    logic        sleeping_o;
    logic        abort_o;
    logic        wake_o;
    logic [15:0] sleep_cycles_o;
    modport master (
        output sleep_req_i, core_busy_i, irq_pending_i, debug_req_i, clr_stats_i,
        input  clock_en_o, sleeping_o, abort_o, wake_o, sleep_cycles_o
    );
    modport slave (
        input  sleep_req_i, core_busy_i, irq_pending_i, debug_req_i, clr_stats_i,
        output clock_en_o, sleeping_o, abort_o, wake_o, sleep_cycles_o
    );
endinterface

// File: rtl/core_sleep_ctrl.sv
// core_sleep_ctrl: drains an idle core, gates its clock while asleep, and restores it on irq/debug.
module core_sleep_ctrl #(
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    core_sleep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_t;
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_stats;
    logic        r_clk_en, r_sleeping, r_abort, r_wake;
    logic        w_wake_evt;
    assign w_wake_evt         = bus.irq_pending_i | bus.debug_req_i;
    assign bus.clock_en_o     = r_clk_en;
    assign bus.sleeping_o     = r_sleeping;
    assign bus.abort_o        = r_abort;
    assign bus.wake_o         = r_wake;
    assign bus.sleep_cycles_o = r_stats;
    // Outputs are written alongside the state transition so they track the registered state exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_stats    <= '0;
            r_clk_en   <= 1'b1;
            r_sleeping <= 1'b0;
            r_abort    <= 1'b0;
            r_wake     <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            r_wake  <= 1'b0;
            case (r_state)
                RUN: if (bus.sleep_req_i && !w_wake_evt) begin
                    r_state <= DRAIN;
                    r_cnt   <= '0;
                end
                DRAIN: if (w_wake_evt || !bus.sleep_req_i) begin
                    r_state <= RUN;
                    r_abort <= 1'b1;
                end else if (bus.core_busy_i) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == IDLE_LAST) begin
                        r_state    <= SLEEP;
                        r_clk_en   <= 1'b0;
                        r_sleeping <= 1'b1;
                    end
                end
                SLEEP: if (w_wake_evt) begin
                    r_state    <= WAKE;
                    r_cnt      <= '0;
                    r_clk_en   <= 1'b1;
                    r_sleeping <= 1'b0;
                end
                WAKE: if (r_cnt == WAKE_LAST) begin
                    r_state <= RUN;
                    r_wake  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                default: r_state <= RUN;
            endcase
            r_stats <= bus.clr_stats_i ? 16'h0000 :
                       (r_state == SLEEP && r_stats != 16'hFFFF) ? r_stats + 16'd1 : r_stats;
        end
    end
endmodule
